store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 st_valid  in  1  CPU store request.
REQ-005 st_ready  out  1  the unit accepts a request in this cycle.
REQ-006 STORESel  in  2  store kind: 00 sw, 01 sb, 10 sh, 11 reserved.
REQ-007 addr  in  9  byte address of the store.
REQ-008 wdata  in  32  store data; sb uses [7:0], sh uses [15:0].
REQ-009 mem_addr  out  7  word index into the data memory (byte address [8:2]).
REQ-010 mem_rdata  in  32  combinational read of the word at mem_addr.
REQ-011 mem_we  out  1  word write strobe to the data memory.
REQ-012 mem_wdata  out  32  word written when mem_we is high.
REQ-013 done  out  1  one-cycle pulse when a store completes or is rejected.
REQ-014 err  out  1  one-cycle pulse, coincident with done, marking a rejected store.

Function
REQ-015 A request SHALL be accepted when st_valid and st_ready are both high; STORESel, addr and wdata SHALL be captured at acceptance.
REQ-016 st_ready SHALL be high only in state IDLE.
REQ-017 States SHALL be IDLE, READ and WRITE.
REQ-018 IDLE -> WRITE on an accepted, aligned sw.
REQ-019 IDLE -> READ on an accepted, aligned sb or sh.
REQ-020 IDLE -> IDLE on an accepted misaligned or reserved request; done and err SHALL pulse in the next cycle, and mem_we SHALL stay low.
REQ-021 Misaligned SHALL mean: sw with addr[1:0] != 0, or sh with addr[0] = 1.
REQ-022 READ: mem_addr SHALL equal the captured addr[8:2]; mem_rdata SHALL be captured at the end of the cycle; the next state SHALL be WRITE.
REQ-023 WRITE: mem_we SHALL be 1 for exactly one cycle, with mem_addr set to the captured addr[8:2]; done SHALL pulse in this cycle; the next state SHALL be IDLE.
REQ-024 sw: mem_wdata = wdata.
REQ-025 sb: mem_wdata = captured word with byte lane addr[1:0] replaced by wdata[7:0]; all other lanes are unchanged.
REQ-026 sh: mem_wdata = captured word with half addr[1] replaced by wdata[15:0]; lane 0 holds bits [15:0], lane 1 holds bits [31:16].
REQ-027 Latency from acceptance to mem_we SHALL be 1 cycle for sw and 2 cycles for sb/sh; throughput SHALL be 1 store per 2 cycles (sw) or 3 cycles (sb/sh).
REQ-028 st_valid while st_ready is low SHALL be ignored and SHALL NOT corrupt the captured request.
REQ-029 Outside WRITE, mem_we SHALL be 0; mem_wdata is don't-care but SHALL be deterministic.
REQ-030 Back-to-back stores to the same word SHALL see the prior write, because READ occurs after the previous WRITE.

Reset
REQ-031 Reset SHALL force state IDLE and mem_we, done and err to 0.
REQ-032 Reset SHALL clear the captured request and data registers to 0.
REQ-033 Reset asserted in READ or WRITE SHALL abort the store with no write, including a WRITE-cycle store cancelled before its clock edge.
REQ-034 st_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 A shared package SHALL hold the STORESel encodings (SEL_SW, SEL_SB, SEL_SH), the state encodings and the widths (word 32, index 7).
REQ-036 One combinational sub-module, store_merge, SHALL perform the byte/half lane insertion (inputs: old word, data, kind, addr[1:0]).

Verification
REQ-037 sw: addr 0x010, wdata 0xDEADBEEF -> mem_we 1 cycle after acceptance, mem_addr 4, mem_wdata 0xDEADBEEF, done in the same cycle.
REQ-038 sb: memory word 0x11223344, addr 0x012, wdata 0x000000AB -> 2 cycles after acceptance, mem_wdata 0x11AB3344.
REQ-039 sh: memory word 0x11223344, addr 0x006, wdata 0x0000CAFE -> mem_wdata 0xCAFE3344 at word index 1.
REQ-040 Misaligned case: sh addr 0x003 -> err and done pulse, no mem_we.
REQ-041 Reserved case: STORESel 11 -> err and done pulse, no mem_we.
REQ-042 Back-to-back: sb addr 0x000 data 0x55, then sb addr 0x001 data 0x66 on the old word 0 -> final word 0x00006655.
REQ-043 Reset in READ -> no mem_we, st_ready 1 after release.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: store kinds, FSM states, datapath widths
// and the alignment rule.
package store_unit_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 7;
  localparam int ADDR_W = 9;

  localparam logic [1:0] SEL_SW  = 2'b00;
  localparam logic [1:0] SEL_SB  = 2'b01;
  localparam logic [1:0] SEL_SH  = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // A request is rejected if it is misaligned for its size or uses the reserved kind.
  function automatic logic is_bad(input logic [1:0] sel, input logic [1:0] lo);
    logic bad;
    case (sel)
      SEL_SW:  bad = (lo != 2'b00);
      SEL_SB:  bad = 1'b0;
      SEL_SH:  bad = lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane insertion: builds the word to write from the old word,
// the store data, the store kind and the byte offset.
module store_merge
  import store_unit_pkg::*;
(
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [1:0]        kind_i,
  input  logic [1:0]        lane_i,
  output logic [WORD_W-1:0] new_word_o
);

  always_comb begin
    new_word_o = old_word_i;
    case (kind_i)
      SEL_SB: begin
        case (lane_i)
          2'd0:    new_word_o[7:0]   = data_i[7:0];
          2'd1:    new_word_o[15:8]  = data_i[7:0];
          2'd2:    new_word_o[23:16] = data_i[7:0];
          default: new_word_o[31:24] = data_i[7:0];
        endcase
      end
      SEL_SH: begin
        if (lane_i[1]) new_word_o[31:16] = data_i[15:0];
        else           new_word_o[15:0]  = data_i[15:0];
      end
      // Full-word store (the reserved kind never reaches WRITE).
      default: new_word_o = data_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts sw/sb/sh requests, performs read-modify-write for
// sub-word stores and rejects misaligned or reserved requests with done+err.
module store_unit
  import store_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [1:0]          STORESel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_W-1:0]   wdata,
  output logic [IDX_W-1:0]    mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                mem_we,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  logic [1:0]          sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                rej_q, rej_d;
  logic                accept;
  logic                bad;

  assign accept = st_valid && (state_q == ST_IDLE);
  assign bad    = is_bad(STORESel, addr[1:0]);

  always_comb begin
    state_d = state_q;
    rej_d   = accept && bad;
    case (state_q)
      ST_IDLE: begin
        if (accept && !bad) state_d = (STORESel == SEL_SW) ? ST_WRITE : ST_READ;
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rej_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rej_q   <= rej_d;
      if (accept) begin
        sel_q   <= STORESel;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      // The READ cycle follows any earlier WRITE, so it sees the prior store.
      if (state_q == ST_READ) rdata_q <= mem_rdata;
    end
  end

  store_merge u_merge (
    .old_word_i (rdata_q),
    .data_i     (wdata_q),
    .kind_i     (sel_q),
    .lane_i     (addr_q[1:0]),
    .new_word_o (mem_wdata)
  );

  assign st_ready = (state_q == ST_IDLE);
  assign mem_addr = addr_q[ADDR_W-1:2];
  assign mem_we   = (state_q == ST_WRITE);
  assign done     = mem_we | rej_q;
  assign err      = rej_q;

endmodule

// File: tb/tb_store_unit.sv
// Randomized scoreboard bench for store_unit with a word-array memory model.
module tb_store_unit;
  import store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  STORESel;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [6:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;

  typedef struct {
    logic        e;
    logic [6:0]  idx;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[128];
  logic [31:0] ref_mem[128];
  logic        load_en = 1'b0;
  logic [6:0]  load_idx = '0;
  logic [31:0] load_val = '0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .STORESel  (STORESel),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (load_en)     mem[load_idx] <= load_val;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done/mem_we/err cycle must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (done || mem_we || err)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output done=%0b we=%0b err=%0b expected no activity",
                   done, mem_we, err);
        end else begin
          e = exp_q.pop_front();
          chk("done", 32'(done), 32'd1);
          chk("err", 32'(err), 32'(e.e));
          chk("mem_we", 32'(mem_we), 32'(!e.e));
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.e) begin
            chk("mem_addr", 32'(mem_addr), 32'(e.idx));
            chk("mem_wdata", mem_wdata, e.d);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] sel, input logic [8:0] a, input logic [31:0] d);
    int          guard;
    exp_t        e;
    logic [31:0] old_w, new_w, mask;
    logic        bad;
    guard = 0;
    while (!st_ready) begin
      st_valid = 1'($urandom_range(0, 1));
      STORESel = 2'($urandom_range(0, 3));
      addr     = 9'($urandom);
      wdata    = $urandom;
      @(negedge clk);
      guard++;
      if (guard > 20) begin
        chk("ready_timeout", 32'(st_ready), 32'd1);
        st_valid = 1'b0;
        return;
      end
    end
    st_valid = 1'b1;
    STORESel = sel;
    addr     = a;
    wdata    = d;
    bad = (sel == 2'b11) || (sel == 2'b00 && a[1:0] != 2'b00) || (sel == 2'b10 && a[0]);
    e.e   = bad;
    e.idx = a[8:2];
    e.d   = '0;
    if (bad) begin
      e.cyc = cyc + 1;
    end else begin
      old_w = ref_mem[a[8:2]];
      if (sel == 2'b00) begin
        new_w = d;
        e.cyc = cyc + 1;
      end else if (sel == 2'b01) begin
        mask  = 32'hFF << (8 * a[1:0]);
        new_w = (old_w & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
        e.cyc = cyc + 2;
      end else begin
        mask  = 32'hFFFF << (16 * a[1]);
        new_w = (old_w & ~mask) | ((d & 32'hFFFF) << (16 * a[1]));
        e.cyc = cyc + 2;
      end
      e.d = new_w;
      ref_mem[a[8:2]] = new_w;
    end
    exp_q.push_back(e);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || !st_ready) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic reset_abort(input logic [1:0] sel, input logic [8:0] a);
    logic [31:0] saved;
    saved    = mem[a[8:2]];
    st_valid = 1'b1;
    STORESel = sel;
    addr     = a;
    wdata    = $urandom;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    st_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after_release", 32'(st_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_word_unchanged", mem[a[8:2]], saved);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    logic [31:0] v;
    logic [1:0]  s;
    logic [8:0]  a;
    rst      = 1'b1;
    st_valid = 1'b0;
    STORESel = '0;
    addr     = '0;
    wdata    = '0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (i == 0)                v = 32'h0;
      else if (i == 1 || i == 4) v = 32'h11223344;
      else                       v = $urandom;
      load_en    = 1'b1;
      load_idx   = 7'(i);
      load_val   = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    load_en = 1'b0;
    chk("reset_st_ready", 32'(st_ready), 32'd1);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(st_ready), 32'd1);

    issue(SEL_SB, 9'h012, 32'h000000AB);
    issue(SEL_SH, 9'h006, 32'h0000CAFE);
    drain();
    chk("sb_word4", mem[4], 32'h11AB3344);
    chk("sh_word1", mem[1], 32'hCAFE3344);

    issue(SEL_SW, 9'h010, 32'hDEADBEEF);
    issue(SEL_SH, 9'h003, 32'h12345678);
    issue(SEL_RSV, 9'h020, 32'h0BADF00D);
    issue(SEL_SB, 9'h000, 32'h00000055);
    issue(SEL_SB, 9'h001, 32'h00000066);
    drain();
    chk("sw_word4", mem[4], 32'hDEADBEEF);
    chk("b2b_word0", mem[0], 32'h00006655);

    reset_abort(SEL_SB, 9'h014);
    reset_abort(SEL_SW, 9'h018);

    for (int n = 0; n < 300; n++) begin
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom);
      issue(s, a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_memory_mismatches", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
